// File: rtl/blink_pkg.sv
// ============================================================================
// Module      : blink_pkg
// Description : Shared state encoding and default constants for blink_sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package blink_pkg;

   typedef logic [1:0] state_t;

   localparam state_t ST_IDLE    = 2'd0;
   localparam state_t ST_LOAD    = 2'd1;
   localparam state_t ST_SHIFT   = 2'd2;
   localparam state_t ST_ADVANCE = 2'd3;

   localparam int unsigned TICK_DIV_30MHZ = 1500000;

   // Defaults are 32 bits wide; each table entry keeps its low PAT_W bits.
   localparam logic [31:0] DEF_PAT [8] = '{
      32'hAAAA_AAAA, 32'hCCCC_CCCC, 32'hF0F0_F0F0, 32'h8181_8181,
      32'h5555_5555, 32'h3333_3333, 32'h0F0F_0F0F, 32'h7E7E_7E7E
   };

   function automatic logic [31:0] def_pat(input logic [2:0] idx);
      return DEF_PAT[idx];
   endfunction

endpackage

`default_nettype wire

// File: rtl/blink_prescaler.sv
// ============================================================================
// Module      : blink_prescaler
// Description : Wrapping 0..DIV-1 counter with enable and clear, tick on DIV-1.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module blink_prescaler
   import blink_pkg::*;
#(
   parameter int unsigned DIV = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   en,
   input  logic                   clr,
   output logic [$clog2(DIV)-1:0] cnt,
   output logic                   tick
);

   localparam int unsigned CNT_W = $clog2(DIV);
   localparam logic [CNT_W-1:0] C_LAST = CNT_W'(DIV - 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             at_last;

   assign at_last = (cnt_q == C_LAST);

   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (en) begin
         cnt_d = at_last ? '0 : cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt  = cnt_q;
   assign tick = en & ~clr & at_last;

endmodule

`default_nettype wire

// File: rtl/blink_sequencer.sv
// ============================================================================
// Module      : blink_sequencer
// Description : Pattern-table LED blinker: load, rotate out at tick rate,
//               repeat, advance. Optional PWM dimming via BLINK_SEQ_PWM_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module blink_sequencer
   import blink_pkg::*;
#(
   parameter int unsigned PAT_W    = 8,
   parameter int unsigned PAT_N    = 4,
   parameter int unsigned TICK_DIV = TICK_DIV_30MHZ,
   parameter int unsigned REPEAT   = 4
) (
   input  logic                     clk30,
   input  logic                     rst,
   input  logic                     run,
   input  logic                     wr_en,
   input  logic [$clog2(PAT_N)-1:0] wr_addr,
   input  logic [PAT_W-1:0]         wr_data,
   input  logic [3:0]               duty,
   output logic                     led,
   output logic [$clog2(PAT_N)-1:0] pat_idx,
   output logic                     pat_done,
   output logic                     busy
);

   localparam int unsigned IDX_W = $clog2(PAT_N);
   localparam int unsigned BIT_W = $clog2(PAT_W);
   localparam int unsigned REP_W = (REPEAT > 1) ? $clog2(REPEAT) : 1;
   localparam logic [BIT_W-1:0] C_LAST_BIT = BIT_W'(PAT_W - 1);
   localparam logic [REP_W-1:0] C_LAST_REP = REP_W'(REPEAT - 1);

   state_t             state_q,   state_d;
   logic [IDX_W-1:0]   pat_idx_q, pat_idx_d;
   logic [PAT_W-1:0]   shift_q,   shift_d;
   logic [BIT_W-1:0]   bitcnt_q,  bitcnt_d;
   logic [REP_W-1:0]   rep_q,     rep_d;
   logic               led_reg_q, led_reg_d;
   logic               pat_done_q, pat_done_d;
   logic               busy_q,    busy_d;
   logic [PAT_W-1:0]   pat_tab_q [PAT_N];
   logic [PAT_W-1:0]   pat_tab_d [PAT_N];

   logic               tick;
   logic               presc_en;
   logic               presc_clr;
   logic [$clog2(TICK_DIV)-1:0] unused_tick_cnt;

   assign presc_en  = (state_q == ST_SHIFT);
   assign presc_clr = (state_q != ST_SHIFT) | ~run;

   blink_prescaler #(
      .DIV (TICK_DIV)
   ) u_tick_presc (
      .clk  (clk30),
      .rst  (rst),
      .en   (presc_en),
      .clr  (presc_clr),
      .cnt  (unused_tick_cnt),
      .tick (tick)
   );

   always_comb begin
      state_d   = state_q;
      pat_idx_d = pat_idx_q;
      shift_d   = shift_q;
      bitcnt_d  = bitcnt_q;
      rep_d     = rep_q;
      led_reg_d = led_reg_q;
      pat_tab_d = pat_tab_q;

      if (wr_en) begin
         pat_tab_d[wr_addr] = wr_data;
      end

      if (!run) begin
         state_d   = ST_IDLE;
         led_reg_d = 1'b0;
         bitcnt_d  = '0;
         rep_d     = '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               led_reg_d = 1'b0;
               state_d   = ST_LOAD;
            end
            ST_LOAD: begin
               // Reads the pre-write table, so a same-cycle write lands next LOAD.
               shift_d  = pat_tab_q[pat_idx_q];
               bitcnt_d = '0;
               rep_d    = '0;
               state_d  = ST_SHIFT;
            end
            ST_SHIFT: begin
               if (tick) begin
                  led_reg_d = shift_q[PAT_W-1];
                  shift_d   = {shift_q[PAT_W-2:0], shift_q[PAT_W-1]};
                  if (bitcnt_q == C_LAST_BIT) begin
                     bitcnt_d = '0;
                     if (rep_q == C_LAST_REP) begin
                        rep_d   = '0;
                        state_d = ST_ADVANCE;
                     end else begin
                        rep_d = rep_q + REP_W'(1);
                     end
                  end else begin
                     bitcnt_d = bitcnt_q + BIT_W'(1);
                  end
               end
            end
            ST_ADVANCE: begin
               pat_idx_d = pat_idx_q + IDX_W'(1);
               state_d   = ST_LOAD;
            end
            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end

      pat_done_d = (state_d == ST_ADVANCE);
      busy_d     = (state_d != ST_IDLE);
   end

   always_ff @(posedge clk30) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         pat_idx_q  <= '0;
         shift_q    <= '0;
         bitcnt_q   <= '0;
         rep_q      <= '0;
         led_reg_q  <= 1'b0;
         pat_done_q <= 1'b0;
         busy_q     <= 1'b0;
         for (int unsigned i = 0; i < PAT_N; i++) begin
            pat_tab_q[i] <= PAT_W'(def_pat(3'(i)));
         end
      end else begin
         state_q    <= state_d;
         pat_idx_q  <= pat_idx_d;
         shift_q    <= shift_d;
         bitcnt_q   <= bitcnt_d;
         rep_q      <= rep_d;
         led_reg_q  <= led_reg_d;
         pat_done_q <= pat_done_d;
         busy_q     <= busy_d;
         pat_tab_q  <= pat_tab_d;
      end
   end

`ifdef BLINK_SEQ_PWM_EN
   logic [3:0] pwm_cnt;
   logic       unused_pwm_tick;
   logic       led_pwm_q, led_pwm_d;

   blink_prescaler #(
      .DIV (16)
   ) u_pwm_cnt (
      .clk  (clk30),
      .rst  (rst),
      .en   (1'b1),
      .clr  (1'b0),
      .cnt  (pwm_cnt),
      .tick (unused_pwm_tick)
   );

   assign led_pwm_d = led_reg_d & (pwm_cnt < duty);

   always_ff @(posedge clk30) begin
      if (rst) begin
         led_pwm_q <= 1'b0;
      end else begin
         led_pwm_q <= led_pwm_d;
      end
   end

   assign led = led_pwm_q;
`else
   logic unused_duty;
   assign unused_duty = ^duty;
   assign led = led_reg_q;
`endif

   assign pat_idx  = pat_idx_q;
   assign pat_done = pat_done_q;
   assign busy     = busy_q;

endmodule

`default_nettype wire
